// File: rtl/symbol_serializer.sv
// symbol_serializer
//
// Splits DATA_W-bit received words into NSYM = DATA_W/SYM_W symbols of SYM_W
// bits and hands them one per output handshake to the branch-metric unit.
// Each word carries its own symbol order (MSB-first or LSB-first), captured
// when the word is accepted. Two word slots are provided: the active slot is
// being emitted, and the pending slot lets the next word wait so consecutive
// words stream with no bubble. Every output is driven from registers only.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active low
//   i_flush      in   synchronous flush, drops both slots
//   i_valid      in   input word valid
//   o_ready      out  input ready (pending slot empty)
//   i_data       in   [DATA_W] input word
//   i_lsb_first  in   order for this word: 0 = MSB symbol first, 1 = LSB first
//   o_valid      out  output symbol valid (active slot full)
//   i_ready      in   downstream ready
//   o_sym        out  [SYM_W] current symbol, 0 when o_valid = 0
//   o_last       out  final symbol of the word, 0 when o_valid = 0
//   o_sym_idx    out  [IDX_W] emission index within the word, 0 when o_valid = 0
//
// Parameter constraints: DATA_W is a multiple of SYM_W, NSYM >= 2,
// 2**IDX_W >= NSYM.

module symbol_serializer #(
    parameter int DATA_W = 16,
    parameter int SYM_W  = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_lsb_first,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [SYM_W-1:0]  o_sym,
    output logic              o_last,
    output logic [IDX_W-1:0]  o_sym_idx
);

    localparam int               NSYM     = DATA_W / SYM_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

    // Active slot
    logic              act_full_q, act_full_d;
    logic [DATA_W-1:0] act_word_q, act_word_d;
    logic              act_lsb_q,  act_lsb_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;

    // Pending slot
    logic              pend_full_q, pend_full_d;
    logic [DATA_W-1:0] pend_word_q, pend_word_d;
    logic              pend_lsb_q,  pend_lsb_d;

    logic out_hs;
    logic in_acc;
    logic is_last;
    logic vacate;

    assign is_last = (idx_q == LAST_IDX);
    assign out_hs  = act_full_q & i_ready;
    assign in_acc  = i_valid & ~pend_full_q;
    assign vacate  = out_hs & is_last;

    // Next-state logic for both slots and the symbol index.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through
        // this block can leave one unassigned and infer a latch.
        act_full_d  = act_full_q;
        act_word_d  = act_word_q;
        act_lsb_d   = act_lsb_q;
        idx_d       = idx_q;
        pend_full_d = pend_full_q;
        pend_word_d = pend_word_q;
        pend_lsb_d  = pend_lsb_q;

        if (i_flush) begin
            // Flush beats any handshake in the same cycle.
            act_full_d  = 1'b0;
            pend_full_d = 1'b0;
            idx_d       = '0;
        end else if (vacate) begin
            // Final symbol leaves: refill from pending first, else from input.
            idx_d = '0;
            if (pend_full_q) begin
                act_word_d  = pend_word_q;
                act_lsb_d   = pend_lsb_q;
                pend_full_d = 1'b0;
            end else if (in_acc) begin
                act_word_d = i_data;
                act_lsb_d  = i_lsb_first;
            end else begin
                act_full_d = 1'b0;
            end
        end else begin
            if (out_hs) begin
                idx_d = idx_q + IDX_W'(1);
            end
            if (in_acc) begin
                if (!act_full_q) begin
                    act_full_d = 1'b1;
                    act_word_d = i_data;
                    act_lsb_d  = i_lsb_first;
                end else begin
                    pend_full_d = 1'b1;
                    pend_word_d = i_data;
                    pend_lsb_d  = i_lsb_first;
                end
            end
        end
    end

    // NOTE: the word registers are reset along with the flags; they are only
    // a few flops, and this keeps o_sym free of X after reset in simulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_full_q  <= 1'b0;
            act_word_q  <= '0;
            act_lsb_q   <= 1'b0;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            pend_word_q <= '0;
            pend_lsb_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            act_full_q  <= act_full_d;
            act_word_q  <= act_word_d;
            act_lsb_q   <= act_lsb_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
            pend_word_q <= pend_word_d;
            pend_lsb_q  <= pend_lsb_d;
        end
    end

    // Symbol select. The emission index maps to a physical symbol position
    // counted from the LSB end: identity for LSB-first, mirrored for MSB-first.
    logic [IDX_W-1:0] pos;
    logic [SYM_W-1:0] sym_sel;

    always_comb begin
        pos     = act_lsb_q ? idx_q : (LAST_IDX - idx_q);
        sym_sel = '0;
        for (int k = 0; k < NSYM; k++) begin
            if (pos == IDX_W'(k)) begin
                sym_sel = act_word_q[k*SYM_W +: SYM_W];
            end
        end
    end

    assign o_ready   = ~pend_full_q;
    assign o_valid   = act_full_q;
    assign o_sym     = act_full_q ? sym_sel : '0;
    assign o_last    = act_full_q & is_last;
    assign o_sym_idx = act_full_q ? idx_q : '0;

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed bench for symbol_serializer: a 16/4 instance and an 8/2 instance
// sharing clock and reset. Expected symbols are hand-derived from the words.

module tb_symbol_serializer;

    logic clk;
    logic rst;

    // 16-bit / 4-bit instance
    logic        i_flush, i_valid, i_lsb_first, i_ready;
    logic [15:0] i_data;
    logic        o_ready, o_valid, o_last;
    logic [3:0]  o_sym;
    logic [1:0]  o_sym_idx;

    // 8-bit / 2-bit instance
    logic        b_flush, b_valid, b_lsb_first, b_ready_in;
    logic [7:0]  b_data;
    logic        b_ready, b_ovalid, b_last;
    logic [1:0]  b_sym;
    logic [1:0]  b_idx;

    int total = 0;
    int bad   = 0;

    symbol_serializer #(.DATA_W(16), .SYM_W(4), .IDX_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_lsb_first (i_lsb_first),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sym       (o_sym),
        .o_last      (o_last),
        .o_sym_idx   (o_sym_idx)
    );

    symbol_serializer #(.DATA_W(8), .SYM_W(2), .IDX_W(2)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (b_flush),
        .i_valid     (b_valid),
        .o_ready     (b_ready),
        .i_data      (b_data),
        .i_lsb_first (b_lsb_first),
        .o_valid     (b_ovalid),
        .i_ready     (b_ready_in),
        .o_sym       (b_sym),
        .o_last      (b_last),
        .o_sym_idx   (b_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current 16-bit output symbol, then advance one cycle.
    task automatic expect_sym(input string tag, input logic [3:0] sym,
                              input logic [1:0] idx, input logic last);
        check({tag, ".valid"}, o_valid, 1);
        check({tag, ".sym"}, o_sym, sym);
        check({tag, ".idx"}, o_sym_idx, idx);
        check({tag, ".last"}, o_last, last);
        tick();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, o_valid, 0);
        check({tag, ".sym"}, o_sym, 0);
        check({tag, ".idx"}, o_sym_idx, 0);
        check({tag, ".last"}, o_last, 0);
        check({tag, ".ready"}, o_ready, 1);
    endtask

    task automatic expect8(input string tag, input logic [1:0] sym,
                           input logic [1:0] idx, input logic last);
        check({tag, ".valid"}, b_ovalid, 1);
        check({tag, ".sym"}, b_sym, sym);
        check({tag, ".idx"}, b_idx, idx);
        check({tag, ".last"}, b_last, last);
        tick();
    endtask

    // Present one word for one cycle; accepted at the edge inside tick().
    task automatic send(input logic [15:0] data, input logic lsb);
        check("send.ready", o_ready, 1);
        i_valid     = 1'b1;
        i_data      = data;
        i_lsb_first = lsb;
        tick();
        i_valid     = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        i_flush = 1'b0; i_valid = 1'b0; i_lsb_first = 1'b0; i_ready = 1'b1; i_data = '0;
        b_flush = 1'b0; b_valid = 1'b0; b_lsb_first = 1'b0; b_ready_in = 1'b1; b_data = '0;

        // Reset state
        #12;
        expect_idle("reset");
        check("reset8.valid", b_ovalid, 0);
        check("reset8.ready", b_ready, 1);
        rst = 1'b1;
        tick();
        expect_idle("post_reset");

        // MSB-first single word
        send(16'hA5C3, 1'b0);
        expect_sym("msb0", 4'hA, 0, 0);
        expect_sym("msb1", 4'h5, 1, 0);
        expect_sym("msb2", 4'hC, 2, 0);
        expect_sym("msb3", 4'h3, 3, 1);
        expect_idle("msb_end");

        // LSB-first single word
        send(16'hA5C3, 1'b1);
        expect_sym("lsb0", 4'h3, 0, 0);
        expect_sym("lsb1", 4'hC, 1, 0);
        expect_sym("lsb2", 4'h5, 2, 0);
        expect_sym("lsb3", 4'hA, 3, 1);
        expect_idle("lsb_end");

        // Back-to-back words with mixed order, no bubble
        send(16'h1234, 1'b0);
        i_valid = 1'b1; i_data = 16'hBEEF; i_lsb_first = 1'b1;
        check("b2b.ready", o_ready, 1);
        expect_sym("b2b_a0", 4'h1, 0, 0);
        i_valid = 1'b0;
        i_lsb_first = 1'b0;   // must not disturb the buffered LSB-first word
        expect_sym("b2b_a1", 4'h2, 1, 0);
        expect_sym("b2b_a2", 4'h3, 2, 0);
        expect_sym("b2b_a3", 4'h4, 3, 1);
        expect_sym("b2b_b0", 4'hF, 0, 0);
        expect_sym("b2b_b1", 4'hE, 1, 0);
        expect_sym("b2b_b2", 4'hE, 2, 0);
        expect_sym("b2b_b3", 4'hB, 3, 1);
        expect_idle("b2b_end");

        // Backpressure: five stalled cycles, one word buffered, a third held off
        i_ready = 1'b0;
        send(16'hA5C3, 1'b0);
        i_valid = 1'b1; i_data = 16'h1111; i_lsb_first = 1'b0;
        check("bp.ready0", o_ready, 1);
        check("bp.stall0", o_sym, 4'hA);
        tick();
        i_data = 16'h2222;
        for (int i = 1; i < 5; i++) begin
            check("bp.stall_sym", o_sym, 4'hA);
            check("bp.stall_idx", o_sym_idx, 0);
            check("bp.stall_last", o_last, 0);
            check("bp.stall_ready", o_ready, 0);
            tick();
        end
        i_ready = 1'b1;
        expect_sym("bp_a0", 4'hA, 0, 0);
        expect_sym("bp_a1", 4'h5, 1, 0);
        expect_sym("bp_a2", 4'hC, 2, 0);
        check("bp.held_ready", o_ready, 0);
        expect_sym("bp_a3", 4'h3, 3, 1);
        check("bp.reopen_ready", o_ready, 1);
        expect_sym("bp_b0", 4'h1, 0, 0);   // 2222 accepted at this edge
        i_valid = 1'b0;
        expect_sym("bp_b1", 4'h1, 1, 0);
        expect_sym("bp_b2", 4'h1, 2, 0);
        expect_sym("bp_b3", 4'h1, 3, 1);
        expect_sym("bp_c0", 4'h2, 0, 0);
        expect_sym("bp_c1", 4'h2, 1, 0);
        expect_sym("bp_c2", 4'h2, 2, 0);
        expect_sym("bp_c3", 4'h2, 3, 1);
        expect_idle("bp_end");

        // Flush at idx 2 with a word pending; same-cycle input must be dropped
        send(16'hA5C3, 1'b0);
        i_valid = 1'b1; i_data = 16'h1111; i_lsb_first = 1'b0;
        expect_sym("fl_a0", 4'hA, 0, 0);
        i_valid = 1'b0;
        expect_sym("fl_a1", 4'h5, 1, 0);
        i_flush = 1'b1;
        i_valid = 1'b1; i_data = 16'h3333;
        check("fl.pre_sym", o_sym, 4'hC);
        check("fl.pre_idx", o_sym_idx, 2);
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        expect_idle("flush");
        send(16'h7E00, 1'b0);
        expect_sym("fl_n0", 4'h7, 0, 0);
        expect_sym("fl_n1", 4'hE, 1, 0);
        expect_sym("fl_n2", 4'h0, 2, 0);
        expect_sym("fl_n3", 4'h0, 3, 1);
        expect_idle("fl_end");

        // Asynchronous reset between edges, mid-word with a word pending
        send(16'hA5C3, 1'b0);
        i_valid = 1'b1; i_data = 16'h1111;
        expect_sym("ar_a0", 4'hA, 0, 0);
        i_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        expect_idle("async_rst");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ar.no_stale", o_valid, 0);
        end

        // 8-bit / 2-bit instance: 0xB4 = 10 11 01 00
        b_valid = 1'b1; b_data = 8'hB4; b_lsb_first = 1'b0;
        tick();
        b_valid = 1'b0;
        expect8("n8_msb0", 2'd2, 0, 0);
        expect8("n8_msb1", 2'd3, 1, 0);
        expect8("n8_msb2", 2'd1, 2, 0);
        expect8("n8_msb3", 2'd0, 3, 1);
        check("n8.idle", b_ovalid, 0);
        b_valid = 1'b1; b_lsb_first = 1'b1;
        tick();
        b_valid = 1'b0;
        expect8("n8_lsb0", 2'd0, 0, 0);
        expect8("n8_lsb1", 2'd1, 1, 0);
        expect8("n8_lsb2", 2'd3, 2, 0);
        expect8("n8_lsb3", 2'd2, 3, 1);
        check("n8.end", b_ovalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
